// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin, frame-locked arbiter feeding byte streams to one UART (optional stall timeout via TX_ARB_TIMEOUT_EN)
module tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic                 tx_busy,
    output logic                 send,
    output logic [7:0]           tx_data,
    output logic [15:0]          frame_cnt,
    output logic                 timeout_err
);
    localparam int W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

    state_t               state, state_d;
    logic [W-1:0]         owner, owner_d, rr_ptr, rr_ptr_d, pick, owner_inc;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [15:0]          frame_cnt_d;
    logic [8*NUM_REQ-1:0] data_sh;
    logic                 last_q, last_d, found, fire, abort;

    // first valid requester scanning from rr_ptr; later offsets overwritten by nearer ones
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick  = W'((int'(rr_ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign data_sh   = req_data >> {owner, 3'b000};
    assign owner_inc = (owner == W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign fire      = (state == S_SEND) && req_valid[owner] && !tx_busy;
    assign send      = fire;
    assign tx_data   = fire ? data_sh[7:0] : 8'h00;
    assign req_ready = fire ? gnt : '0;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          stall;

    assign stall = ((state == S_SEND) && !req_valid[owner]) || (state == S_WAIT_HI) || (state == S_WAIT_LO);
    assign abort = stall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // stall counter restarts whenever the FSM moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else
            tmo_cnt <= (state_d != state) ? '0 : stall ? tmo_cnt + 1'b1 : tmo_cnt;
    end
`else
    assign abort = 1'b0;
`endif

    assign timeout_err = abort;

    // next-state: arbitration in idle, then byte handshake with the UART until the last byte drains
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        rr_ptr_d    = rr_ptr;
        gnt_d       = gnt;
        last_d      = last_q;
        frame_cnt_d = frame_cnt;
        if (abort) begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            rr_ptr_d = owner_inc;
        end else begin
            case (state)
                S_IDLE: if (found) begin
                    owner_d = pick;
                    gnt_d   = NUM_REQ'(1) << pick;
                    state_d = S_SEND;
                end
                S_SEND: if (fire) begin
                    last_d  = req_last[owner];
                    state_d = S_WAIT_HI;
                end
                S_WAIT_HI: state_d = tx_busy ? S_WAIT_LO : S_WAIT_HI;
                S_WAIT_LO: if (!tx_busy) begin
                    state_d = last_q ? S_IDLE : S_SEND;
                    if (last_q) begin
                        gnt_d       = '0;
                        frame_cnt_d = frame_cnt + 16'd1;
                        rr_ptr_d    = owner_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state registers, cleared asynchronously so an interrupted frame is dropped at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            gnt       <= '0;
            last_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            rr_ptr    <= rr_ptr_d;
            gnt       <= gnt_d;
            last_q    <= last_d;
            frame_cnt <= frame_cnt_d;
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter with byte-queue requesters and a fixed-latency UART model
module tb_tx_arbiter;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_last, req_ready, gnt;
    logic [8*N-1:0] req_data;
    logic           tx_busy, send, timeout_err;
    logic [7:0]     tx_data;
    logic [15:0]    frame_cnt;

    always #5 clk = ~clk;

    tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .gnt(gnt), .tx_busy(tx_busy),
        .send(send), .tx_data(tx_data), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
    );

    logic [8:0]  rq [N][$];
    logic [10:0] exp_q[$];
    int          glog[$];
    int          n_tests = 0, n_fail = 0, sends = 0, tmo_pulses = 0, bcnt = 0, busy_len = 3;
    logic        hold_busy = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    assign tx_busy = hold_busy || (bcnt > 0);

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = rq[i].size() > 0;
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] pop, eg;
        logic [10:0]  e;
        logic         s;
        @(negedge clk);
        s   = send;
        pop = req_ready;
        if (timeout_err) tmo_pulses++;
        if (gnt != prev_gnt && gnt != '0)
            for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
        prev_gnt = gnt;
        n_tests++;
        if ((req_ready & ~gnt) != '0 || (!send && req_ready != '0) || (send && req_ready !== gnt)) begin
            n_fail++;
            $display("FAIL ready_owner: req_ready=%b gnt=%b send=%b", req_ready, gnt, send);
        end
        n_tests++;
        if (send) begin
            sends++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_send: tx_data=%h gnt=%b, no byte expected", tx_data, gnt);
            end else begin
                e  = exp_q.pop_front();
                eg = '0;
                eg[int'(e[10:8])] = 1'b1;
                if (tx_data !== e[7:0] || gnt !== eg) begin
                    n_fail++;
                    $display("FAIL byte: tx_data=%h gnt=%b expected tx_data=%h gnt=%b", tx_data, gnt, e[7:0], eg);
                end
            end
        end else if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_data: tx_data=%h expected 00 while send=0", tx_data);
        end
        @(posedge clk);
        #1;
        bcnt = s ? busy_len : (bcnt > 0 ? bcnt - 1 : 0);
        for (int i = 0; i < N; i++) if (pop[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive();
    endtask

    task automatic run_idle(input int limit);
        int k = 0;
        while (k < limit && !(rq[0].size() == 0 && rq[1].size() == 0 && exp_q.size() == 0 && gnt == '0 && !tx_busy)) begin
            cycle();
            k++;
        end
        n_tests++;
        if (k >= limit) begin
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, %0d bytes outstanding", limit, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bcnt  = 0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        drive();
    endtask

    task automatic test_reset();
        apply_reset();
        rq[0].push_back({1'b1, 8'h3C});
        drive();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (gnt !== '0 || send !== 1'b0 || tx_data !== 8'h00 || req_ready !== '0 || frame_cnt !== 16'd0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b send=%b tx_data=%h req_ready=%b frame_cnt=%0d timeout_err=%b expected all zero",
                     gnt, send, tx_data, req_ready, frame_cnt, timeout_err);
        end
        rq[0].delete();
        drive();
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int s0 = sends;
        glog.delete();
        rq[0].push_back({1'b0, 8'h01});
        rq[0].push_back({1'b1, 8'hAA});
        exp_q.push_back({3'd0, 8'h01});
        exp_q.push_back({3'd0, 8'hAA});
        drive();
        run_idle(100);
        n_tests++;
        if (sends - s0 != 2 || frame_cnt !== 16'd1 || gnt !== '0) begin
            n_fail++;
            $display("FAIL single_frame: sends=%0d frame_cnt=%0d gnt=%b expected sends=2 frame_cnt=1 gnt=00", sends - s0, frame_cnt, gnt);
        end
        n_tests++;
        if (glog.size() != 1 || glog[0] != 0) begin
            n_fail++;
            $display("FAIL single_grant: %0d grants, expected exactly one to requester 0", glog.size());
        end
    endtask

    task automatic test_contention();
        apply_reset();
        rq[0].push_back({1'b0, 8'h10});
        rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b0, 8'h20});
        rq[1].push_back({1'b1, 8'h21});
        exp_q.push_back({3'd0, 8'h10});
        exp_q.push_back({3'd0, 8'h11});
        exp_q.push_back({3'd1, 8'h20});
        exp_q.push_back({3'd1, 8'h21});
        drive();
        glog.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_idle(200);
        n_tests++;
        if (frame_cnt !== 16'd2 || glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
            n_fail++;
            $display("FAIL contention: frame_cnt=%0d grants=%0d expected frame_cnt=2 grants 0 then 1", frame_cnt, glog.size());
        end
    endtask

    task automatic test_fairness();
        glog.delete();
        for (int k = 0; k < 3; k++) begin
            rq[0].push_back({1'b0, 8'hA0 + 8'(k)});
            rq[0].push_back({1'b1, 8'hB0 + 8'(k)});
            rq[1].push_back({1'b1, 8'hC0 + 8'(k)});
            exp_q.push_back({3'd0, 8'hA0 + 8'(k)});
            exp_q.push_back({3'd0, 8'hB0 + 8'(k)});
            exp_q.push_back({3'd1, 8'hC0 + 8'(k)});
        end
        drive();
        run_idle(400);
        n_tests++;
        if (glog.size() != 6) begin
            n_fail++;
            $display("FAIL fair_count: %0d grants expected 6", glog.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (glog[k] != k % 2) begin
                    n_fail++;
                    $display("FAIL fair_order[%0d]: granted %0d expected %0d", k, glog[k], k % 2);
                end
            end
        end
        n_tests++;
        if (frame_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL fair_frames: frame_cnt=%0d expected 8", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int s0 = sends;
        hold_busy = 1'b1;
        rq[0].push_back({1'b1, 8'h5C});
        exp_q.push_back({3'd0, 8'h5C});
        drive();
        repeat (20) cycle();
        n_tests++;
        if (sends != s0 || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_hold: sends=%0d gnt=%b expected sends=0 gnt=01 while busy", sends - s0, gnt);
        end
        hold_busy = 1'b0;
        cycle();
        n_tests++;
        if (sends != s0 + 1) begin
            n_fail++;
            $display("FAIL bp_release: sends=%0d expected 1 on first non-busy cycle", sends - s0);
        end
        run_idle(100);
        n_tests++;
        if (frame_cnt !== 16'd9) begin
            n_fail++;
            $display("FAIL bp_frames: frame_cnt=%0d expected 9", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0 = sends;
        int k = 0;
        for (int b = 0; b < 4; b++) rq[0].push_back({b == 3, 8'h40 + 8'(b)});
        exp_q.push_back({3'd0, 8'h40});
        exp_q.push_back({3'd0, 8'h41});
        drive();
        while (sends - s0 < 2 && k < 100) begin
            cycle();
            k++;
        end
        cycle();
        cycle();
        n_tests++;
        if (k >= 100 || gnt !== 2'b01 || !tx_busy) begin
            n_fail++;
            $display("FAIL mid_setup: gnt=%b tx_busy=%b after %0d cycles, expected owner 0 waiting on UART", gnt, tx_busy, k);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (gnt !== '0 || send !== 1'b0 || req_ready !== '0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: gnt=%b send=%b req_ready=%b frame_cnt=%0d expected all zero", gnt, send, req_ready, frame_cnt);
        end
        apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rq[1].push_back({1'b0, 8'h61});
        rq[1].push_back({1'b1, 8'h62});
        exp_q.push_back({3'd1, 8'h61});
        exp_q.push_back({3'd1, 8'h62});
        drive();
        run_idle(100);
        n_tests++;
        if (frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_restart: frame_cnt=%0d expected 1", frame_cnt);
        end
    endtask

`ifdef TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int s0 = sends;
        int t0 = tmo_pulses;
        int k = 0;
        logic [15:0] fc = frame_cnt;
        rq[1].push_back({1'b0, 8'h77});
        exp_q.push_back({3'd1, 8'h77});
        drive();
        while (sends == s0 && k < 50) begin
            cycle();
            k++;
        end
        glog.delete();
        rq[0].push_back({1'b1, 8'h99});
        exp_q.push_back({3'd0, 8'h99});
        drive();
        run_idle(200);
        n_tests++;
        if (tmo_pulses - t0 != 1 || frame_cnt !== fc + 16'd1 || glog.size() != 1 || glog[0] != 0) begin
            n_fail++;
            $display("FAIL timeout: pulses=%0d frame_cnt=%0d grants=%0d expected pulses=1 frame_cnt=%0d then requester 0",
                     tmo_pulses - t0, frame_cnt, glog.size(), fc + 16'd1);
        end
    endtask
`endif

    initial begin
        drive();
        test_reset();
        test_single_frame();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid_frame();
`ifdef TX_ARB_TIMEOUT_EN
        test_timeout();
`else
        n_tests++;
        if (tmo_pulses != 0) begin
            n_fail++;
            $display("FAIL timeout_tied: %0d timeout_err pulses, expected 0", tmo_pulses);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of byte-stream requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, stall limit in clocks, used only with TX_ARB_TIMEOUT_EN.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; ports are clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester byte available.
REQ-007 req_data  in  8*NUM_REQ  per-requester byte; requester i owns bits [8i+7:8i].
REQ-008 req_last  in  NUM_REQ  byte is the final byte of its frame.
REQ-009 req_ready  out  NUM_REQ  byte of requester i accepted this cycle (combinational, one-hot or zero).
REQ-010 gnt  out  NUM_REQ  registered one-hot owner of the UART; zero when idle.
REQ-011 tx_busy  in  1  UART transmitter busy.
REQ-012 send  out  1  one-cycle byte-launch strobe to UART.
REQ-013 tx_data  out  8  byte to UART, valid when send=1, else 8'h00.
REQ-014 frame_cnt  out  16  completed frames, wraps 16'hFFFF->0.
REQ-015 timeout_err  out  1  one-cycle pulse on frame abort.

Function
REQ-016 States: S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO.
REQ-017 S_IDLE: pick first requester with req_valid=1 searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; register gnt and go S_SEND next cycle; no request -> stay.
REQ-018 S_SEND: if req_valid[owner]=1 and tx_busy=0 -> send=1, tx_data=owner byte, req_ready[owner]=1, capture req_last into last_q, go S_WAIT_HI; otherwise hold with send=0.
REQ-019 S_WAIT_HI: wait for tx_busy=1, then go S_WAIT_LO.
REQ-020 S_WAIT_LO: on tx_busy=0, if last_q=1 -> gnt=0, frame_cnt+1, rr_ptr=owner+1 mod NUM_REQ, go S_IDLE; else go S_SEND with same owner.
REQ-021 Frame lock: no other requester is served until the owner's last byte completes (or abort); other req_valid inputs are ignored mid-frame.
REQ-022 Minimum per-byte cost: 1 cycle S_SEND + 1 cycle S_WAIT_HI + UART busy time; arbitration adds 1 cycle per frame.
REQ-023 req_ready SHALL never assert for a non-owner and never outside S_SEND.
REQ-024 Single-byte frame (req_last=1 on first byte) is legal and counted once.
REQ-025 Simultaneous requests from all requesters: each served exactly one frame in rotating order before any repeats.
REQ-026 rr_ptr at NUM_REQ-1 advancing SHALL wrap to 0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=S_IDLE, gnt=0, rr_ptr=0, last_q=0, frame_cnt=0, timeout counter=0.
REQ-028 During and after reset send=0, tx_data=8'h00, req_ready=0, timeout_err=0; a frame interrupted by reset is abandoned and not counted.

Configuration
REQ-029 Macro TX_ARB_TIMEOUT_EN defined: a counter increments each cycle in S_SEND with req_valid[owner]=0, or in S_WAIT_HI/S_WAIT_LO, and clears on any state change; reaching TIMEOUT_CYCLES-1 SHALL pulse timeout_err, clear gnt, advance rr_ptr past owner, not increment frame_cnt, go S_IDLE.
REQ-030 Macro undefined: no timeout logic, block waits indefinitely, timeout_err tied to 0.

Verification
REQ-031 Single frame: req0 sends 8'h01,8'hAA(last), UART busy 3 cycles per byte -> tx_data 01 then AA, two send pulses, frame_cnt=1, gnt=0 after.
REQ-032 Contention: req0 and req1 both valid from reset with 2-byte frames -> req0 frame fully, then req1 frame, bytes never interleaved, frame_cnt=2.
REQ-033 Fairness: both requesters continuously valid for 6 frames -> grant order 0,1,0,1,0,1.
REQ-034 Backpressure: tx_busy held high 20 cycles in S_SEND -> send stays 0, req_ready stays 0, byte issued on first cycle tx_busy=0.
REQ-035 Reset mid-frame: assert rst_n=0 during S_WAIT_LO of byte 2 of 4 -> gnt=0, send=0 same cycle, frame_cnt=0, next frame starts cleanly.
REQ-036 With TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: req1 drops req_valid after first byte -> timeout_err pulses once after 16 stalled cycles, gnt=0, frame_cnt unchanged, req0 served next.
